// File: rtl/lcd_arb_pkg.sv
// lcd_arb_pkg
//   Shared definitions for the LCD write arbiter: the arbiter state
//   encoding, RS values, the common HD44780-style command bytes used by the
//   display-content generators, and the default settle delay.
package lcd_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_SETTLE = 3'd3,
      S_ACK    = 3'd4
   } arb_state_t;

   localparam logic RS_CMD  = 1'b0;
   localparam logic RS_CHAR = 1'b1;

   localparam logic [7:0] LCD_FUNC_SET  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] LCD_DISP_ON   = 8'h0C;  // display on, cursor off
   localparam logic [7:0] LCD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_ENTRY     = 8'h06;  // increment, no shift
   localparam logic [7:0] LCD_LINE1     = 8'h80;  // cursor to line 1, column 0
   localparam logic [7:0] LCD_LINE2     = 8'hC0;  // cursor to line 2, column 0

   localparam int DLY_W_DEF      = 18;
   localparam int DLY_CYCLES_DEF = 262143;

endpackage

// File: rtl/lcd_dly_timer.sv
// lcd_dly_timer
//   Loadable down-counter. load has priority and sets the count; while en is
//   high the count decrements until it reaches zero and then holds.
//   expired is high whenever the count is zero, so a value of N-1 loaded on
//   entry gives exactly N enabled cycles before expired is seen.
// Ports:
//   clk, rst   clock, synchronous active-high reset (count -> 0)
//   load       load load_val into the counter
//   load_val   W-bit reload value
//   en         decrement enable
//   expired    count is zero
module lcd_dly_timer
   import lcd_arb_pkg::*;
#(
   parameter int W = DLY_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//   Shares one LCD_Controller byte interface between two requesters.
//   Round-robin arbitration, start/done sequencing, a post-write settle
//   delay, and a per-requester lock so a whole display line can be streamed
//   without interleaving.
//
//   Requester handshake: a requester raises iREQn with iDATAn/iRSn/iLOCKn
//   stable and holds them until oACKn. The byte is latched on grant; oACKn
//   is a one-cycle pulse after the controller has finished and the settle
//   delay has elapsed. iLOCKn is sampled in the ACK cycle. A request still
//   high in the cycle after oACKn is a new byte.
//
//   Optional feature (macro LCD_DONE_TIMEOUT_EN): bounds the wait for
//   iLCD_DONE to TO_CYCLES; on expiry the write is abandoned, sticky oERR is
//   set and the byte is still settled and acknowledged.
//
// Ports:
//   iCLK, iRST                 clock, synchronous active-high reset
//   iREQn/iDATAn/iRSn/iLOCKn   requester n byte request, byte, RS, lock
//   oACKn                      requester n byte-complete pulse
//   oLCD_DATA/oLCD_RS/oLCD_START  to LCD_Controller iDATA/iRS/iStart
//   iLCD_DONE                  from LCD_Controller oDone
//   oGNT                       current or last owner
//   oBUSY                      state is not IDLE
//   oERR                       sticky done-timeout flag
module lcd_write_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int DLY_W      = DLY_W_DEF,
   parameter int DLY_CYCLES = DLY_CYCLES_DEF,
   parameter int TO_W       = 20,
   parameter int TO_CYCLES  = 1000000
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iREQ0,
   input  logic [7:0] iDATA0,
   input  logic       iRS0,
   input  logic       iLOCK0,
   output logic       oACK0,
   input  logic       iREQ1,
   input  logic [7:0] iDATA1,
   input  logic       iRS1,
   input  logic       iLOCK1,
   output logic       oACK1,
   output logic [7:0] oLCD_DATA,
   output logic       oLCD_RS,
   output logic       oLCD_START,
   input  logic       iLCD_DONE,
   output logic       oGNT,
   output logic       oBUSY,
   output logic       oERR
);

   // Elaboration-time range checks on the delay parameters.
   if (DLY_CYCLES < 1 || DLY_CYCLES >= (2 ** DLY_W)) begin : g_bad_dly
      $error("lcd_write_arbiter: DLY_CYCLES out of range for DLY_W");
   end
   if (TO_CYCLES < 1 || TO_CYCLES >= (2 ** TO_W)) begin : g_bad_to
      $error("lcd_write_arbiter: TO_CYCLES out of range for TO_W");
   end

   arb_state_t state_q, state_d;
   logic [7:0] data_q, data_d;
   logic       rs_q, rs_d;
   logic       start_q, start_d;
   logic       gnt_q, gnt_d;
   logic       ptr_q, ptr_d;      // last requester that received an ACK
   logic       lock_q, lock_d;
   logic       owner_q, owner_d;

   logic       el0, el1, pick;
   logic       dly_load, dly_expired;
   logic       timeout;

`ifdef LCD_DONE_TIMEOUT_EN
   logic       err_q, err_d;
   logic       to_load, to_expired;

   // Loaded with TO_CYCLES-1 on grant, so oLCD_START is high for at most
   // TO_CYCLES cycles across ISSUE and WAIT.
   lcd_dly_timer #(.W(TO_W)) u_to_timer (
      .clk      (iCLK),
      .rst      (iRST),
      .load     (to_load),
      .load_val (TO_W'(TO_CYCLES - 1)),
      .en       ((state_q == S_ISSUE) || (state_q == S_WAIT)),
      .expired  (to_expired)
   );

   assign timeout = to_expired;
   assign oERR    = err_q;
`else
   assign timeout = 1'b0;
   assign oERR    = 1'b0;
`endif

   // Loaded with DLY_CYCLES-1 when the controller finishes, so SETTLE lasts
   // exactly DLY_CYCLES cycles.
   lcd_dly_timer #(.W(DLY_W)) u_settle_timer (
      .clk      (iCLK),
      .rst      (iRST),
      .load     (dly_load),
      .load_val (DLY_W'(DLY_CYCLES - 1)),
      .en       (state_q == S_SETTLE),
      .expired  (dly_expired)
   );

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      rs_d     = rs_q;
      start_d  = start_q;
      gnt_d    = gnt_q;
      ptr_d    = ptr_q;
      lock_d   = lock_q;
      owner_d  = owner_q;
      dly_load = 1'b0;
`ifdef LCD_DONE_TIMEOUT_EN
      to_load  = 1'b0;
      err_d    = err_q;
`endif

      // While locked only the owner may be granted.
      el0  = iREQ0 && (!lock_q || (owner_q == 1'b0));
      el1  = iREQ1 && (!lock_q || (owner_q == 1'b1));
      pick = (el0 && el1) ? ~ptr_q : el1;

      unique case (state_q)
         S_IDLE: begin
            if (el0 || el1) begin
               data_d  = pick ? iDATA1 : iDATA0;
               rs_d    = pick ? iRS1 : iRS0;
               gnt_d   = pick;
               start_d = 1'b1;
               state_d = S_ISSUE;
`ifdef LCD_DONE_TIMEOUT_EN
               to_load = 1'b1;
`endif
            end
         end
         // ISSUE is the first cycle of oLCD_START; a done seen there is
         // honoured the same way as in WAIT.
         S_ISSUE, S_WAIT: begin
            if (iLCD_DONE) begin
               start_d  = 1'b0;
               dly_load = 1'b1;
               state_d  = S_SETTLE;
            end else if (timeout) begin
               start_d  = 1'b0;
               dly_load = 1'b1;
               state_d  = S_SETTLE;
`ifdef LCD_DONE_TIMEOUT_EN
               err_d    = 1'b1;
`endif
            end else begin
               state_d  = S_WAIT;
            end
         end
         S_SETTLE: begin
            if (dly_expired) begin
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            ptr_d   = gnt_q;
            lock_d  = gnt_q ? iLOCK1 : iLOCK0;
            owner_d = gnt_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= S_IDLE;
         data_q  <= 8'h00;
         rs_q    <= RS_CMD;
         start_q <= 1'b0;
         gnt_q   <= 1'b0;
         ptr_q   <= 1'b1;   // requester 0 wins the first contention
         lock_q  <= 1'b0;
         owner_q <= 1'b0;
`ifdef LCD_DONE_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         start_q <= start_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         owner_q <= owner_d;
`ifdef LCD_DONE_TIMEOUT_EN
         err_q   <= err_d;
`endif
      end
   end

   assign oLCD_DATA  = data_q;
   assign oLCD_RS    = rs_q;
   assign oLCD_START = start_q;
   assign oGNT       = gnt_q;
   assign oBUSY      = (state_q != S_IDLE);
   assign oACK0      = (state_q == S_ACK) && (gnt_q == 1'b0);
   assign oACK1      = (state_q == S_ACK) && (gnt_q == 1'b1);

endmodule
